// File: rtl/cnt_flag_gen.sv
// ============================================================================
// Module      : cnt_flag_gen
// Description : Parametrised up/down event counter with terminal/zero level
//               flags, a one-cycle terminal pulse and a saturating
//               wrap-event counter. Optional build macro CNT_PRESCALE_EN
//               inserts a divide-by-PRE_DIV prescaler on the step request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_flag_gen #(
  parameter int CNT_W   = 8,
  parameter int CNT_MAX = 100,
  parameter int WRAP_W  = 8,
  parameter int PRE_DIV = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cnt_en,
  input  logic              cnt_clr,
  input  logic              load_en,
  input  logic [CNT_W-1:0]  load_val,
  input  logic              dir_down,
  input  logic              mode_wrap,
  output logic [CNT_W-1:0]  cnt,
  output logic              po_flag,
  output logic              po_zero,
  output logic              po_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  // Terminal value in counter width; also the reload value on a down-wrap.
  localparam logic [CNT_W-1:0] c_cnt_max    = CNT_W'(CNT_MAX);
  // Value one below terminal: an up-step from here lands on terminal.
  localparam logic [CNT_W-1:0] c_cnt_max_m1 = CNT_W'(CNT_MAX - 1);
  // Value one above zero: a down-step from here lands on zero.
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

`ifdef CNT_PRESCALE_EN
  // A ratio below 2 would be meaningless; treat it as "no prescaling".
  localparam bit c_pre_on = (PRE_DIV >= 2);
`else
  // Prescaler compiled out; PRE_DIV has no effect in this build.
  localparam bit c_pre_on = 1'b0 && (PRE_DIV >= 2);
`endif

  logic [CNT_W-1:0]  r_cnt;
  logic              r_pulse;
  logic [WRAP_W-1:0] r_wrap;

  logic              w_step;        // a counter step happens this cycle
  logic [CNT_W-1:0]  w_step_cnt;    // count value after a step
  logic              w_step_wrap;   // the step is a wrap event
  logic              w_step_pulse;  // the step lands on the terminal value
  logic [CNT_W-1:0]  w_load_cnt;    // load value clamped to the terminal

  // --------------------------------------------------------------------------
  // Step qualification
  // --------------------------------------------------------------------------
  generate
    if (c_pre_on) begin : g_prescale
      localparam int               c_pre_w    = $clog2(PRE_DIV);
      localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRE_DIV - 1);

      logic [c_pre_w-1:0] r_pre;

      // Prescaler advances on every cnt_en cycle and restarts on any
      // reset, clear or load so the next step is a full period away.
      always_ff @(posedge sys_clk) begin
        if (sys_rst || cnt_clr || load_en) begin
          r_pre <= '0;
        end else if (cnt_en) begin
          if (r_pre == c_pre_last) begin
            r_pre <= '0;
          end else begin
            r_pre <= r_pre + 1'b1;
          end
        end
      end

      // Only the request on which the prescaler rolls over becomes a step.
      assign w_step = cnt_en && (r_pre == c_pre_last);
    end else begin : g_direct
      // Every request is a step.
      assign w_step = cnt_en;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-value computation
  // --------------------------------------------------------------------------

  // Load values above the terminal are clamped so the count never exceeds it.
  assign w_load_cnt = (load_val > c_cnt_max) ? c_cnt_max : load_val;

  // Result of a step: the range check happens before the add/subtract, so
  // the arithmetic never overflows; holding at the terminal yields no pulse.
  always_comb begin
    w_step_cnt   = r_cnt;
    w_step_wrap  = 1'b0;
    w_step_pulse = 1'b0;
    if (!dir_down) begin
      if (r_cnt < c_cnt_max) begin
        w_step_cnt   = r_cnt + 1'b1;
        w_step_pulse = (r_cnt == c_cnt_max_m1);
      end else if (mode_wrap) begin
        // Up-wrap lands on zero, which is not the up terminal: no pulse.
        w_step_cnt  = '0;
        w_step_wrap = 1'b1;
      end
    end else begin
      if (r_cnt != '0) begin
        w_step_cnt   = r_cnt - 1'b1;
        w_step_pulse = (r_cnt == c_cnt_one);
      end else if (mode_wrap) begin
        // Down-wrap reloads the terminal, never zero (CNT_MAX >= 1): no pulse.
        w_step_cnt  = c_cnt_max;
        w_step_wrap = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------

  // Count, pulse and wrap counter with priority reset > clear > load > step.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_wrap  <= '0;
    end else if (cnt_clr) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (load_en) begin
      r_cnt   <= w_load_cnt;
      r_pulse <= 1'b0;
    end else if (w_step) begin
      r_cnt   <= w_step_cnt;
      r_pulse <= w_step_pulse;
      if (w_step_wrap && (r_wrap != {WRAP_W{1'b1}})) begin
        r_wrap <= r_wrap + 1'b1;
      end
    end else begin
      r_pulse <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: level flags decode the count register directly.
  // --------------------------------------------------------------------------
  assign cnt      = r_cnt;
  assign po_flag  = (r_cnt == c_cnt_max);
  assign po_zero  = (r_cnt == '0);
  assign po_pulse = r_pulse;
  assign wrap_cnt = r_wrap;

endmodule

`default_nettype wire
